// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the fetch sequencer.
//   - FSM state encodings (legacy constants) and the state enum built on them
//   - default widths for PC, branch-target table and cycle counter
//   - power-on contents of the 16-entry branch-target table
package fetch_pkg;

    localparam int unsigned FETCH_PC_W  = 10;
    localparam int unsigned FETCH_LUT_N = 16;
    localparam int unsigned FETCH_CNT_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } fetch_state_e;

    // Default branch targets: entry i points at address i*32.
    localparam logic [9:0] FETCH_LUT_DEFAULT [16] = '{
        10'h000, 10'h020, 10'h040, 10'h060,
        10'h080, 10'h0A0, 10'h0C0, 10'h0E0,
        10'h100, 10'h120, 10'h140, 10'h160,
        10'h180, 10'h1A0, 10'h1C0, 10'h1E0
    };

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: handshake, decode and table-write signals between the
// testbench/decoder side (master) and the fetch sequencer (slave).
//   master drives: Start, StartAddr, BranchEn, CondFlag, LutIdx, Halt, Stall,
//                  LutWe, LutWaddr, LutWdata
//   slave drives:  ProgCtr, Fetch, Done, CycleCount
interface fetch_unit_if #(
    parameter int unsigned PC_W  = 10,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 16
);
    logic             Start;
    logic [PC_W-1:0]  StartAddr;
    logic             BranchEn;
    logic             CondFlag;
    logic [IDX_W-1:0] LutIdx;
    logic             Halt;
    logic             Stall;
    logic             LutWe;
    logic [IDX_W-1:0] LutWaddr;
    logic [PC_W-1:0]  LutWdata;
    logic [PC_W-1:0]  ProgCtr;
    logic             Fetch;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;

    modport master (
        output Start, StartAddr, BranchEn, CondFlag, LutIdx, Halt, Stall,
               LutWe, LutWaddr, LutWdata,
        input  ProgCtr, Fetch, Done, CycleCount
    );

    modport slave (
        input  Start, StartAddr, BranchEn, CondFlag, LutIdx, Halt, Stall,
               LutWe, LutWaddr, LutWdata,
        output ProgCtr, Fetch, Done, CycleCount
    );
endinterface

// File: rtl/branch_lut.sv
// branch_lut: LUT_N x PC_W branch-target register file.
//   clk    - clock, rising edge
//   reset  - synchronous, active-low; reloads package default targets
//   we     - write enable (gated by the caller)
//   waddr  - write index
//   wdata  - write data
//   raddr  - read index (asynchronous read)
//   rdata  - target at raddr
module branch_lut
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W  = FETCH_PC_W,
    parameter int unsigned LUT_N = FETCH_LUT_N,
    parameter int unsigned IDX_W = $clog2(LUT_N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [PC_W-1:0]  wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [PC_W-1:0]  rdata
);

    logic [PC_W-1:0] mem [LUT_N];

    always_ff @(posedge clk) begin
        if (!reset) begin
            // Default table has 16 entries; larger tables repeat it.
            for (int unsigned i = 0; i < LUT_N; i++) begin
                mem[i] <= PC_W'(FETCH_LUT_DEFAULT[i % FETCH_LUT_N]);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch sequencer.
//   Clk    - clock, all state updates on rising edge
//   Reset  - synchronous, active-low
//   bus    - fetch_unit_if slave: start/done handshake, branch/halt/stall
//            decode inputs, branch-table write port, ProgCtr/Fetch/Done/
//            CycleCount outputs
// IDLE -> RUN on Start (PC <= StartAddr, count cleared); RUN -> DONE on Halt;
// DONE -> IDLE once Start is released. Outputs are decoded from registers only.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W  = FETCH_PC_W,
    parameter int unsigned LUT_N = FETCH_LUT_N,
    parameter int unsigned CNT_W = FETCH_CNT_W
) (
    input  logic Clk,
    input  logic Reset,
    fetch_unit_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(LUT_N);

    fetch_state_e     state;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt;
    logic [PC_W-1:0]  lut_target;
    logic             lut_we;
    logic             taken;

    // Table is only writable while idle.
    assign lut_we = (state == IDLE) && bus.LutWe;
    assign taken  = bus.BranchEn && bus.CondFlag;

    branch_lut #(
        .PC_W  (PC_W),
        .LUT_N (LUT_N),
        .IDX_W (IDX_W)
    ) u_lut (
        .clk   (Clk),
        .reset (Reset),
        .we    (lut_we),
        .waddr (bus.LutWaddr),
        .wdata (bus.LutWdata),
        .raddr (bus.LutIdx),
        .rdata (lut_target)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        state <= RUN;
                        pc    <= bus.StartAddr;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // Stall overrides everything: PC and count frozen.
                    if (!bus.Stall) begin
                        if (cnt != '1) begin
                            cnt <= cnt + 1'b1;
                        end
                        if (bus.Halt) begin
                            state <= DONE;
                        end else if (taken) begin
                            pc <= lut_target;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!bus.Start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ProgCtr    = pc;
    assign bus.CycleCount = cnt;
    assign bus.Fetch      = (state == RUN);
    assign bus.Done       = (state == DONE);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch sequencer for the 9-bit CSE141L core; it consumes `BranchEn` from the control decoder plus an ALU condition flag and produces the instruction-ROM address each cycle. It holds a 16-entry absolute branch-target table, runs a start/done handshake with the testbench, stalls on request, and counts executed cycles. It sits between the control decoder/ALU and the instruction ROM.

## Interface
- `PC_W`, 10, program counter / instruction-ROM address width
- `LUT_N`, 16, branch-target table entries (index width = log2(`LUT_N`))
- `CNT_W`, 16, cycle counter width
- `Clk` in 1, single clock; all state updates on rising edge
- `Reset` in 1, synchronous, active-low; sampled on `Clk` rising edge
- `Start` in 1, request to begin execution (level, sampled in IDLE)
- `StartAddr` in `PC_W`, first instruction address, captured with `Start`
- `BranchEn` in 1, decoded branch instruction present (from control decoder)
- `CondFlag` in 1, ALU condition; branch taken = `BranchEn & CondFlag`
- `LutIdx` in 4, branch-target table index from the current instruction
- `Halt` in 1, decoded halt instruction present
- `Stall` in 1, hold PC this cycle
- `LutWe` in 1, table write enable (honoured in IDLE only)
- `LutWaddr` in 4, table write index
- `LutWdata` in `PC_W`, table write data
- `ProgCtr` out `PC_W`, instruction-ROM address
- `Fetch` out 1, high while in RUN (ROM output is a live instruction)
- `Done` out 1, high while in DONE
- `CycleCount` out `CNT_W`, RUN cycles since last accepted `Start`, saturating

## Operation
- States: IDLE, RUN, DONE. Reset (`Reset`=0 at an edge) forces IDLE, `ProgCtr`=0, `CycleCount`=0, `Fetch`=0, `Done`=0; table contents reload to package defaults. Reset mid-RUN aborts with no `Done`.
- IDLE: `Start`=1 -> RUN, `ProgCtr`<=`StartAddr`, `CycleCount`<=0. `LutWe`=1 writes `LutWdata` to entry `LutWaddr`; ignored in RUN/DONE. Write and `Start` in the same cycle: both take effect.
- RUN, next-PC priority (highest first): `Stall` -> hold PC, no count; `Halt` -> DONE, PC holds; taken branch -> PC<=table[`LutIdx`]; else PC<=PC+1 modulo 2^`PC_W` (0x3FF wraps to 0x000).
- `BranchEn`=1 with `CondFlag`=0: falls through to PC+1. `CondFlag` alone has no effect.
- `CycleCount` increments on every non-stalled RUN cycle including the `Halt` cycle; saturates at 2^`CNT_W`-1.
- DONE: outputs hold; returns to IDLE only when `Start`=0. `Start` held high through DONE does not restart.

## Timing
- `Start` sampled at edge N -> `ProgCtr`=`StartAddr`, `Fetch`=1 after edge N.
- Branch/increment: one-cycle latency; decision inputs at edge N set `ProgCtr` after edge N; no bubbles.
- `Halt` at edge N -> `Done`=1, `Fetch`=0 after edge N.
- Table read combinational within the cycle; a write in IDLE is visible in the first RUN cycle.
- All outputs registered or decoded from registered state only; no input-to-output combinational path.

## Structure
- Package `fetch_pkg`: state enum (IDLE/RUN/DONE), `PC_W`/`LUT_N` defaults, 16-entry default target array.
- Sub-module `branch_lut`: `LUT_N`x`PC_W` register file, one sync write port, one async read port, reset to package defaults.
- `fetch_unit`: FSM, PC register, next-PC mux, cycle counter.

## Test plan
- Reset then `Start`=1, `StartAddr`=0x010, no branches, 5 cycles -> `ProgCtr` 0x010..0x014, `Fetch`=1, `CycleCount`=5.
- Write table[3]=0x200 in IDLE, start at 0, at PC=0x002 drive `BranchEn`=1,`CondFlag`=1,`LutIdx`=3 -> next `ProgCtr`=0x200; same with `CondFlag`=0 -> 0x003.
- `StartAddr`=0x3FE, run 3 cycles -> 0x3FE, 0x3FF, 0x000.
- At PC=0x005 assert `Stall` 2 cycles together with taken branch -> PC stays 0x005 and count frozen; on release branch taken.
- `Halt` at PC=0x007 after start at 0 -> next cycle `Done`=1, `Fetch`=0, `ProgCtr`=0x007, `CycleCount`=8; hold `Start`=1 -> stays DONE; drop `Start` -> IDLE.
- `Reset`=0 mid-RUN at PC=0x040 -> next edge IDLE, `ProgCtr`=0, `CycleCount`=0, `Done`=0; `LutWe` during RUN leaves table unchanged.
